// File: rtl/spi_link_pkg.sv
// Shared types and constants for the SPI link controllers.
package spi_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int BYTE_W   = 8;
  localparam int BITCNT_W = $clog2(BYTE_W);
  localparam int MAX_REQ  = 8;

  // Highest set bit index of a one-hot vector; zero for an all-zero vector.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (oh[k]) idx = 3'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/spi_link_arbiter_if.sv
// Client-side request bus plus the 4-wire link towards the SPI slave.
interface spi_link_arbiter_if
  import spi_link_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        last;
  logic [NUM_REQ*BYTE_W-1:0] wdata;
  logic [NUM_REQ-1:0]        ack;
  logic [IDW-1:0]            owner;
  logic                      busy;
  logic [BYTE_W-1:0]         rdata;
  logic                      rvalid;
  logic                      cs;
  logic                      mosi;
  logic                      miso;

  modport master (
    input  req, last, wdata, miso,
    output ack, owner, busy, rdata, rvalid, cs, mosi
  );

  modport slave (
    output req, last, wdata, miso,
    input  ack, owner, busy, rdata, rvalid, cs, mosi
  );
endinterface

// File: rtl/spi_link_rr_arb.sv
// Combinational requester select: round-robin when SPI_ARB_RR_EN is defined,
// otherwise fixed priority with the lowest index winning.
module spi_link_rr_arb
  import spi_link_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
`ifdef SPI_ARB_RR_EN
  input  logic [IDW-1:0]     i_rr_ptr,
`endif
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDW-1:0]     o_idx
);

  logic [NUM_REQ-1:0] w_grant;
  logic [MAX_REQ-1:0] w_grant_pad;

`ifdef SPI_ARB_RR_EN
  logic w_found;
  int   w_cand;

  // Search starts just after the previous winner, so it has the lowest priority.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = (int'(i_rr_ptr) + k) % NUM_REQ;
      if (!w_found && i_req[w_cand]) begin
        w_grant[w_cand] = 1'b1;
        w_found         = 1'b1;
      end
    end
  end
`else
  always_comb begin
    w_grant = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        w_grant    = '0;
        w_grant[k] = 1'b1;
      end
    end
  end
`endif

  assign w_grant_pad = MAX_REQ'(w_grant);
  assign o_grant     = w_grant;
  assign o_idx       = IDW'(onehot_to_idx(w_grant_pad));

endmodule

// File: rtl/spi_link_arbiter.sv
// Single-master SPI controller sharing one link among NUM_REQ requesters.
// SPI_ARB_RR_EN selects round-robin arbitration instead of fixed priority.
module spi_link_arbiter
  import spi_link_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GAP_CYC = 2,
  parameter int IDW     = 2
) (
  input logic               sclk,
  input logic               rst,
  spi_link_arbiter_if.master bus
);

  localparam int GAP_EFF = (GAP_CYC < 1) ? 1 : GAP_CYC;
  localparam int GAP_W   = $clog2(GAP_EFF) + 1;

  state_t                r_state, w_state_next;
  logic [IDW-1:0]        r_owner, w_owner_next;
  logic                  r_busy, w_busy_next;
  logic [NUM_REQ-1:0]    r_ack, w_ack_next;
  logic [BYTE_W-2:0]     r_shreg, w_shreg_next;
  logic                  r_lastq, w_lastq_next;
  logic                  r_cs, w_cs_next;
  logic                  r_mosi, w_mosi_next;
  logic [BITCNT_W-1:0]   r_bitcnt, w_bitcnt_next;
  logic [BYTE_W-2:0]     r_rx, w_rx_next;
  logic [BYTE_W-1:0]     r_rdata, w_rdata_next;
  logic                  r_rvalid, w_rvalid_next;
  logic [GAP_W-1:0]      r_gapcnt, w_gapcnt_next;
`ifdef SPI_ARB_RR_EN
  logic [IDW-1:0]        r_rr_ptr, w_rr_ptr_next;
`endif

  logic [NUM_REQ-1:0]    w_win_grant;
  logic [IDW-1:0]        w_win_idx;
  logic [IDW-1:0]        w_sel;
  logic [BYTE_W-1:0]     w_sel_byte;
  logic                  w_sel_last;

  spi_link_rr_arb #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
    .i_req    (bus.req),
`ifdef SPI_ARB_RR_EN
    .i_rr_ptr (r_rr_ptr),
`endif
    .o_grant  (w_win_grant),
    .o_idx    (w_win_idx)
  );

  // The byte source is the arbitration winner at grant, the owner afterwards.
  assign w_sel      = (r_state == ST_IDLE) ? w_win_idx : r_owner;
  assign w_sel_byte = bus.wdata[int'(w_sel) * BYTE_W +: BYTE_W];
  assign w_sel_last = bus.last[w_sel];

  always_comb begin
    w_state_next  = r_state;
    w_owner_next  = r_owner;
    w_busy_next   = r_busy;
    w_ack_next    = '0;
    w_shreg_next  = r_shreg;
    w_lastq_next  = r_lastq;
    w_cs_next     = r_cs;
    w_mosi_next   = r_mosi;
    w_bitcnt_next = r_bitcnt;
    w_rx_next     = r_rx;
    w_rdata_next  = r_rdata;
    w_rvalid_next = 1'b0;
    w_gapcnt_next = r_gapcnt;
`ifdef SPI_ARB_RR_EN
    w_rr_ptr_next = r_rr_ptr;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (|bus.req) begin
          w_owner_next  = w_win_idx;
          w_busy_next   = 1'b1;
          w_ack_next    = w_win_grant;
          w_shreg_next  = w_sel_byte[BYTE_W-2:0];
          w_lastq_next  = w_sel_last;
          w_cs_next     = 1'b0;
          w_mosi_next   = w_sel_byte[BYTE_W-1];
          w_bitcnt_next = '0;
          w_state_next  = ST_SHIFT;
`ifdef SPI_ARB_RR_EN
          w_rr_ptr_next = w_win_idx;
`endif
        end
      end
      ST_SHIFT: begin
        w_rx_next     = {r_rx[BYTE_W-3:0], bus.miso};
        w_bitcnt_next = r_bitcnt + 1'b1;
        w_shreg_next  = {r_shreg[BYTE_W-3:0], 1'b0};
        w_mosi_next   = r_shreg[BYTE_W-2];
        if (r_bitcnt == BITCNT_W'(BYTE_W - 1)) begin
          w_rdata_next  = {r_rx, bus.miso};
          w_rvalid_next = 1'b1;
          // Back-to-back bytes keep cs low; the bit counter wraps to zero.
          if (!r_lastq) begin
            w_ack_next   = NUM_REQ'(1) << r_owner;
            w_shreg_next = w_sel_byte[BYTE_W-2:0];
            w_lastq_next = w_sel_last;
            w_mosi_next  = w_sel_byte[BYTE_W-1];
          end else begin
            w_cs_next     = 1'b1;
            w_mosi_next   = 1'b0;
            w_gapcnt_next = '0;
            w_state_next  = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (r_gapcnt == GAP_W'(GAP_EFF - 1)) begin
          w_state_next = ST_IDLE;
          w_busy_next  = 1'b0;
        end else begin
          w_gapcnt_next = r_gapcnt + 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_owner  <= '0;
      r_busy   <= 1'b0;
      r_ack    <= '0;
      r_shreg  <= '0;
      r_lastq  <= 1'b0;
      r_cs     <= 1'b1;
      r_mosi   <= 1'b0;
      r_bitcnt <= '0;
      r_rx     <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_gapcnt <= '0;
`ifdef SPI_ARB_RR_EN
      r_rr_ptr <= '0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_owner  <= w_owner_next;
      r_busy   <= w_busy_next;
      r_ack    <= w_ack_next;
      r_shreg  <= w_shreg_next;
      r_lastq  <= w_lastq_next;
      r_cs     <= w_cs_next;
      r_mosi   <= w_mosi_next;
      r_bitcnt <= w_bitcnt_next;
      r_rx     <= w_rx_next;
      r_rdata  <= w_rdata_next;
      r_rvalid <= w_rvalid_next;
      r_gapcnt <= w_gapcnt_next;
`ifdef SPI_ARB_RR_EN
      r_rr_ptr <= w_rr_ptr_next;
`endif
    end
  end

  assign bus.ack    = r_ack;
  assign bus.owner  = r_owner;
  assign bus.busy   = r_busy;
  assign bus.rdata  = r_rdata;
  assign bus.rvalid = r_rvalid;
  assign bus.cs     = r_cs;
  assign bus.mosi   = r_mosi;

endmodule

// File: tb/tb_spi_link_arbiter.sv
// Directed bench for spi_link_arbiter: byte-queue requesters, SPI slave model, run recorders.
module tb_spi_link_arbiter;

  localparam int NUM_REQ = 4;
  localparam int GAP_CYC = 2;
  localparam int IDW     = 2;

  logic sclk = 1'b0;
  logic rst  = 1'b1;
  always #5 sclk = ~sclk;

  spi_link_arbiter_if #(.NUM_REQ(NUM_REQ), .IDW(IDW)) spi ();

  spi_link_arbiter #(.NUM_REQ(NUM_REQ), .GAP_CYC(GAP_CYC), .IDW(IDW)) dut (
    .sclk (sclk),
    .rst  (rst),
    .bus  (spi)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Requester byte queues and recorders
  typedef logic [7:0] bq_t[$];
  bq_t        txq [NUM_REQ];
  int         ack_q[$], ack_t_q[$], rv_t_q[$], cs_low_q[$], cs_high_q[$], busy_q[$];
  logic [7:0] rd_q[$], sl_q[$];
  logic       mosi_q[$];
  int         cyc = 0, cs_run = 0, busy_run = 0, ack_idx = 0;
  logic       cs_prev = 1'b1, busy_prev = 1'b0, seen_low = 1'b0, last_acked = 1'b1;

  // SPI slave model: shifts mosi in while cs is low, returns slv_tx MSB-first
  logic [7:0] slv_tx = 8'hC3;
  logic [6:0] slv_sh = '0;
  logic [2:0] slv_cnt = '0;
  assign spi.miso = (spi.cs === 1'b0) ? slv_tx[3'd7 - slv_cnt] : 1'b0;

  always @(posedge sclk) begin
    if (spi.cs !== 1'b0) begin
      slv_cnt <= '0;
    end else begin
      slv_sh  <= {slv_sh[5:0], spi.mosi};
      slv_cnt <= slv_cnt + 3'd1;
      if (slv_cnt == 3'd7) sl_q.push_back({slv_sh, spi.mosi});
    end
  end

  always @(posedge sclk) begin
    if (!rst && spi.cs === 1'b0 && !last_acked)
      assert (spi.req[spi.owner] === 1'b1)
        else $error("protocol violation: req[%0d] dropped mid-transaction", spi.owner);
  end

  // Monitor first, then requester drivers, all on the falling edge
  always @(negedge sclk) begin
    cyc++;
    if (spi.ack != '0) begin
      for (int i = 0; i < NUM_REQ; i++) if (spi.ack[i]) ack_idx = i;
      check("ack_is_owner", 32'(spi.ack), 32'(1) << spi.owner);
      ack_q.push_back(ack_idx);
      ack_t_q.push_back(cyc);
      last_acked = spi.last[ack_idx];
      if (txq[ack_idx].size() > 0) void'(txq[ack_idx].pop_front());
    end
    if (spi.rvalid === 1'b1) begin
      rd_q.push_back(spi.rdata);
      rv_t_q.push_back(cyc);
    end
    if (spi.cs === 1'b0) mosi_q.push_back(spi.mosi);
    if (spi.cs !== cs_prev) begin
      if (spi.cs === 1'b1) begin
        cs_low_q.push_back(cs_run);
        seen_low = 1'b1;
      end else if (seen_low) begin
        cs_high_q.push_back(cs_run);
      end
      cs_run = 1;
    end else begin
      cs_run++;
    end
    cs_prev = spi.cs;
    if (spi.busy !== busy_prev) begin
      if (spi.busy !== 1'b1) busy_q.push_back(busy_run);
      busy_run = 1;
    end else begin
      busy_run++;
    end
    busy_prev = spi.busy;
    for (int i = 0; i < NUM_REQ; i++) begin
      spi.req[i]         = (txq[i].size() != 0);
      spi.last[i]        = (txq[i].size() == 1);
      spi.wdata[i*8 +: 8] = (txq[i].size() != 0) ? txq[i][0] : 8'h00;
    end
  end

  function automatic bit all_empty();
    for (int i = 0; i < NUM_REQ; i++) if (txq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_rec();
    ack_q.delete(); ack_t_q.delete(); rv_t_q.delete(); rd_q.delete(); sl_q.delete();
    cs_low_q.delete(); cs_high_q.delete(); busy_q.delete(); mosi_q.delete();
    seen_low = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge sclk); #2;
      if (all_empty() && spi.busy === 1'b0) begin ok = 1'b1; break; end
    end
    check({tag, "_timeout"}, 32'(ok), 32'd1);
    repeat (2) @(negedge sclk);
    #2;
  endtask

  // sel 0 waits on ack count, sel 1 on rvalid count
  task automatic wait_q(input int sel, input int n, input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if ((sel == 0 ? ack_q.size() : rd_q.size()) >= n) begin ok = 1'b1; break; end
      @(negedge sclk); #2;
    end
    check({tag, "_wait"}, 32'(ok), 32'd1);
  endtask

  task automatic apply_reset();
    @(negedge sclk); #2;
    rst = 1'b1;
    repeat (2) @(negedge sclk);
    #2;
    rst = 1'b0;
    @(negedge sclk); #2;
  endtask

  int         exp3 [4];
  int         exp3b[5];
  logic [7:0] mb;
  int         first;

  initial begin
`ifdef SPI_ARB_RR_EN
    exp3  = '{1, 2, 3, 0};
    exp3b = '{1, 2, 3, 0, 1};
`else
    exp3  = '{0, 1, 2, 3};
    exp3b = '{0, 0, 1, 2, 3};
`endif
    // Reset values
    repeat (3) @(negedge sclk);
    #2;
    check("rst_cs", 32'(spi.cs), 32'd1);
    check("rst_mosi", 32'(spi.mosi), 32'd0);
    check("rst_ack", 32'(spi.ack), 32'd0);
    check("rst_owner", 32'(spi.owner), 32'd0);
    check("rst_busy", 32'(spi.busy), 32'd0);
    check("rst_rdata", 32'(spi.rdata), 32'd0);
    check("rst_rvalid", 32'(spi.rvalid), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge sclk);
    #2;
    check("idle_cs", 32'(spi.cs), 32'd1);
    check("idle_busy", 32'(spi.busy), 32'd0);

    // Single byte 0xA5 from requester 0
    clear_rec();
    txq[0].push_back(8'hA5);
    wait_done(100, "t1");
    check("t1_cs_runs", cs_low_q.size(), 1);
    check("t1_cs_low", cs_low_q[0], 8);
    check("t1_mosi_bits", mosi_q.size(), 8);
    mb = '0;
    foreach (mosi_q[i]) mb = {mb[6:0], mosi_q[i]};
    check("t1_mosi_seq", 32'(mb), 32'hA5);
    check("t1_acks", ack_q.size(), 1);
    check("t1_ack_idx", ack_q[0], 0);
    check("t1_slave", 32'(sl_q[0]), 32'hA5);
    check("t1_rdata", 32'(rd_q[0]), 32'hC3);
    check("t1_busy_len", busy_q[0], 8 + GAP_CYC);
    $display("t1 single byte: owner=%0d slave=0x%0h rdata=0x%0h", ack_q[0], sl_q[0], rd_q[0]);

    // Three-byte burst from requester 2
    clear_rec();
    txq[2].push_back(8'h3C); txq[2].push_back(8'hF0); txq[2].push_back(8'h81);
    wait_done(200, "t2");
    check("t2_cs_runs", cs_low_q.size(), 1);
    check("t2_cs_low", cs_low_q[0], 24);
    check("t2_acks", ack_q.size(), 3);
    for (int k = 0; k < 3; k++) check($sformatf("t2_ack_idx%0d", k), ack_q[k], 2);
    check("t2_ack_gap1", ack_t_q[1] - ack_t_q[0], 8);
    check("t2_ack_gap2", ack_t_q[2] - ack_t_q[1], 8);
    check("t2_slave0", 32'(sl_q[0]), 32'h3C);
    check("t2_slave1", 32'(sl_q[1]), 32'hF0);
    check("t2_slave2", 32'(sl_q[2]), 32'h81);
    check("t2_rvalids", rd_q.size(), 3);
    check("t2_busy_len", busy_q[0], 24 + GAP_CYC);
    $display("t2 burst: cs_low=%0d acks=%0d rvalids=%0d", cs_low_q[0], ack_q.size(), rd_q.size());

    // Contention, one byte each, from a fresh reset
    apply_reset();
    clear_rec();
    for (int i = 0; i < NUM_REQ; i++) txq[i].push_back(8'h10 + 8'(i) * 8'h11);
    wait_done(400, "t3");
    check("t3_acks", ack_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3_order%0d", k), ack_q[k], exp3[k]);
      check($sformatf("t3_slave%0d", k), 32'(sl_q[k]), 32'(8'h10 + 8'(exp3[k]) * 8'h11));
    end
    // The gap plus the IDLE cycle in which the next grant is sampled
    check("t3_gaps", cs_high_q.size(), 3);
    for (int k = 0; k < 3; k++) check($sformatf("t3_gap%0d", k), cs_high_q[k], GAP_CYC + 1);
    $display("t3 contention: order=%0d,%0d,%0d,%0d", ack_q[0], ack_q[1], ack_q[2], ack_q[3]);

    // First winner re-requests right after its grant
    clear_rec();
    for (int i = 0; i < NUM_REQ; i++) txq[i].push_back(8'h60 + 8'(i));
    wait_q(0, 1, "t3b");
    first = ack_q[0];
    txq[first].push_back(8'h99);
    wait_done(500, "t3b");
    check("t3b_acks", ack_q.size(), 5);
    for (int k = 0; k < 5; k++) check($sformatf("t3b_order%0d", k), ack_q[k], exp3b[k]);
    check("t3b_slave_cnt", sl_q.size(), 5);
    $display("t3b re-request: order=%0d,%0d,%0d,%0d,%0d", ack_q[0], ack_q[1], ack_q[2], ack_q[3], ack_q[4]);

    // Loopback: slave returns 0x5A
    clear_rec();
    slv_tx = 8'h5A;
    txq[3].push_back(8'h0F);
    wait_done(100, "t4");
    check("t4_rvalids", rd_q.size(), 1);
    check("t4_rdata", 32'(rd_q[0]), 32'h5A);
    check("t4_rv_timing", rv_t_q[0] - ack_t_q[0], 8);
    check("t4_slave", 32'(sl_q[0]), 32'h0F);
    $display("t4 loopback: rdata=0x%0h slave=0x%0h", rd_q[0], sl_q[0]);

    // Reset at bit 4 of a byte
    clear_rec();
    slv_tx = 8'hC3;
    txq[1].push_back(8'h77);
    wait_q(0, 1, "t5");
    repeat (4) @(negedge sclk);
    #2;
    rst = 1'b1;
    #1;
    check("t5_cs_async", 32'(spi.cs), 32'd1);
    check("t5_busy_async", 32'(spi.busy), 32'd0);
    check("t5_mosi_async", 32'(spi.mosi), 32'd0);
    foreach (txq[i]) txq[i].delete();
    repeat (3) @(negedge sclk);
    #2;
    rst = 1'b0;
    check("t5_no_rvalid", rd_q.size(), 0);
    check("t5_no_slave_byte", sl_q.size(), 0);
    clear_rec();
    txq[2].push_back(8'h96);
    wait_done(100, "t5b");
    check("t5_slave_cnt", sl_q.size(), 1);
    check("t5_slave", 32'(sl_q[0]), 32'h96);
    check("t5_rdata", 32'(rd_q[0]), 32'hC3);
    $display("t5 reset mid-byte: post-reset slave=0x%0h rdata=0x%0h", sl_q[0], rd_q[0]);

    // Request arriving during GAP
    clear_rec();
    txq[0].push_back(8'h11);
    wait_q(1, 1, "t6");
    check("t6_busy_in_gap", 32'(spi.busy), 32'd1);
    check("t6_cs_in_gap", 32'(spi.cs), 32'd1);
    txq[1].push_back(8'h22);
    wait_done(150, "t6");
    check("t6_acks", ack_q.size(), 2);
    check("t6_order0", ack_q[0], 0);
    check("t6_order1", ack_q[1], 1);
    check("t6_gap", cs_high_q[0], GAP_CYC + 1);
    check("t6_slave1", 32'(sl_q[1]), 32'h22);
    $display("t6 gap request: cs_high=%0d second=0x%0h", cs_high_q[0], sl_q[1]);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
